// File: rtl/bridge_pkg.sv
// Shared types and constants for the sys_bridge_n CPU-to-peripheral bridge.
package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [31:0] ERR_RDATA     = 32'hFFFF_FFFF;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_7f00;
  localparam logic [31:0] DEF_STRIDE    = 32'h0000_0010;
  localparam logic [31:0] DEF_SPAN      = 32'h0000_000C;

  // Width needed to hold a timeout count of 0..timeout.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/bridge_addr_decode.sv
// Combinational window decoder: byte address to one-hot slot hit vector.
module bridge_addr_decode #(
  parameter int          N_DEV     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f00,
  parameter logic [31:0] STRIDE    = 32'h0000_0010,
  parameter logic [31:0] SPAN      = 32'h0000_000C
) (
  input  logic [31:0]      addr,
  output logic [N_DEV-1:0] hit,
  output logic             any_hit
);

  logic [31:0] lo;

  // Offset test against the slot base avoids computing an inclusive upper bound.
  always_comb begin
    hit = '0;
    lo  = '0;
    for (int i = 0; i < N_DEV; i++) begin
      lo = BASE_ADDR + STRIDE * 32'(i);
      if ((addr >= lo) && ((addr - lo) < SPAN)) hit[i] = 1'b1;
    end
  end

  assign any_hit = |hit;

endmodule

// File: rtl/sys_bridge_n.sv
// Parametrised CPU-to-peripheral bridge with per-slot ack, timeout and irq forwarding.
// Optional macro BRIDGE_IRQ_SYNC_EN: two-flop synchronizer on dev_irq instead of one register.
module sys_bridge_n
  import bridge_pkg::*;
#(
  parameter int          N_DEV     = 4,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [31:0] STRIDE    = DEF_STRIDE,
  parameter logic [31:0] SPAN      = DEF_SPAN,
  parameter int          TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [31:0]          pr_addr,
  input  logic [31:0]          pr_wd,
  input  logic [3:0]           pr_be,
  input  logic                 pr_we,
  input  logic                 pr_re,
  output logic [31:0]          pr_rd,
  output logic                 pr_ready,
  output logic                 pr_err,
  output logic [29:0]          dev_addr,
  output logic [31:0]          dev_wd,
  output logic [3:0]           dev_be,
  output logic [N_DEV-1:0]     dev_we,
  output logic [N_DEV-1:0]     dev_re,
  input  logic [32*N_DEV-1:0]  dev_rd,
  input  logic [N_DEV-1:0]     dev_ack,
  input  logic [N_DEV-1:0]     dev_irq,
  output logic [N_DEV-1:0]     irq_out,
  output logic [1:0]           dbg_state
);

  localparam int CW = cnt_width(TIMEOUT);

  // CPU side: request held until the one-cycle pr_ready pulse; requests outside IDLE are ignored.
  // Device side: strobe for the selected slot held until that slot's ack or timeout.
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_DEV-1:0] sel_q, sel_d;
  logic             we_q, we_d;
  logic [29:0]      addr_q, addr_d;
  logic [31:0]      wd_q, wd_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      rd_q, rd_d;
  logic             err_q, err_d;

  logic [N_DEV-1:0] hit;
  logic             any_hit;
  logic [31:0]      rd_mux;
  logic             ack_sel;

  bridge_addr_decode #(
    .N_DEV(N_DEV), .BASE_ADDR(BASE_ADDR), .STRIDE(STRIDE), .SPAN(SPAN)
  ) u_decode (
    .addr(pr_addr), .hit(hit), .any_hit(any_hit)
  );

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (sel_q[i]) rd_mux = dev_rd[32*i +: 32];
    end
  end

  assign ack_sel = |(dev_ack & sel_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    be_d    = be_q;
    rd_d    = rd_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (pr_we || pr_re) begin
          addr_d = pr_addr[31:2];
          wd_d   = pr_wd;
          be_d   = pr_be;
          we_d   = pr_we;
          sel_d  = hit;
          if (any_hit) begin
            state_d = ACCESS;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
            rd_d    = ERR_RDATA;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        // An ack on the final allowed cycle still wins over the timeout.
        if (ack_sel) begin
          state_d = RESP;
          err_d   = 1'b0;
          rd_d    = we_q ? 32'h0 : rd_mux;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
          rd_d    = ERR_RDATA;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  assign pr_ready  = (state_q == RESP);
  assign pr_rd     = rd_q;
  assign pr_err    = err_q;
  assign dev_addr  = addr_q;
  assign dev_wd    = wd_q;
  assign dev_be    = be_q;
  assign dev_we    = ((state_q == ACCESS) && we_q)  ? sel_q : '0;
  assign dev_re    = ((state_q == ACCESS) && !we_q) ? sel_q : '0;
  assign dbg_state = state_q;

`ifdef BRIDGE_IRQ_SYNC_EN
  logic [N_DEV-1:0] irq_s1_q, irq_s2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_s1_q <= '0;
      irq_s2_q <= '0;
    end else begin
      irq_s1_q <= dev_irq;
      irq_s2_q <= irq_s1_q;
    end
  end

  assign irq_out = irq_s2_q;
`else
  logic [N_DEV-1:0] irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= '0;
    else          irq_q <= dev_irq;
  end

  assign irq_out = irq_q;
`endif

endmodule

// File: doc/sys_bridge_n.md
Name: sys_bridge_n

Overview:
- Parametrised CPU-to-peripheral bridge; successor to the fixed two-timer bridge.
- Decodes N_DEV equally spaced device windows and issues registered, one-hot read/write strobes.
- Waits for a per-device acknowledge, with a timeout; flags unmapped or timed-out accesses as bus errors.
- Sits between the CPU memory stage and the timer/UART/GPIO devices; also aggregates device interrupts for the CP0 hardware-interrupt input.

Parameters:
- N_DEV, 4, number of device slots (1..8)
- BASE_ADDR, 32'h0000_7f00, byte address of slot 0
- STRIDE, 32'h10, byte distance between slot bases (power of two)
- SPAN, 32'hC, bytes decoded per slot starting at its base (SPAN <= STRIDE)
- TIMEOUT, 15, max cycles in ACCESS without ack before error (1..255)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- pr_addr  in  32  CPU byte address
- pr_wd  in  32  CPU write data
- pr_be  in  4  CPU byte enables
- pr_we  in  1  CPU write request
- pr_re  in  1  CPU read request
- pr_rd  out  32  read data, valid while pr_ready
- pr_ready  out  1  one-cycle completion pulse
- pr_err  out  1  error flag, valid with pr_ready
- dev_addr  out  30  latched word address [31:2]
- dev_wd  out  32  latched write data
- dev_be  out  4  latched byte enables
- dev_we  out  N_DEV  one-hot write strobe
- dev_re  out  N_DEV  one-hot read strobe
- dev_rd  in  32*N_DEV  packed device read data; slot i at [32i+31:32i]
- dev_ack  in  N_DEV  device completion
- dev_irq  in  N_DEV  device interrupt requests
- irq_out  out  N_DEV  interrupts to CP0

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; all strobes, pr_ready, pr_err 0; pr_rd, dev_addr, dev_wd, dev_be, irq_out 0; timeout counter 0.
- Decode: slot i hits iff BASE_ADDR+i*STRIDE <= pr_addr <= BASE_ADDR+i*STRIDE+SPAN-1. At most one slot can hit. Decode is done on pr_addr in IDLE and registered as a one-hot slot select.
- FSM: three states.
  - IDLE: if pr_we|pr_re, latch addr/wd/be, direction, and slot select. Go to ACCESS on a hit, otherwise to RESP with err=1. If pr_we and pr_re are both 1, the access is a write.
  - ACCESS: drive dev_we or dev_re for the selected slot only, held constant; counter increments each cycle.
    - dev_ack of the selected slot sampled high: capture dev_rd slice into pr_rd (writes capture 0), err=0, go to RESP.
    - Counter reaches TIMEOUT without ack: err=1, pr_rd=32'hFFFF_FFFF, go to RESP.
    - Acks from non-selected slots are ignored.
  - RESP: pr_ready=1 for exactly one cycle with pr_rd/pr_err; strobes 0; counter cleared; next state IDLE.
- Errored reads return 32'hFFFF_FFFF. Errored writes return pr_rd=32'hFFFF_FFFF and produce no device strobe.
- Latency: request in IDLE at cycle 0 → strobe at cycle 1 → ack at cycle k≥1 → pr_ready at k+1. Unmapped access gives pr_ready at cycle 1. The earliest next acceptance is the cycle after RESP.
- Requests arriving while not IDLE are ignored. The CPU holds its request (stall) until pr_ready.
- Reset asserted mid-ACCESS: strobes drop immediately (asynchronous); the transaction is abandoned with no pr_ready.
- dev_addr, dev_wd, and dev_be are stable from ACCESS entry to RESP exit.
- Interrupts: irq_out is dev_irq registered (1 cycle) by default; no masking is done in the bridge.

Optional Feature:
- BRIDGE_IRQ_SYNC_EN defined: dev_irq passes through a two-flop synchronizer per bit. irq_out lags by 2 cycles, and both flop stages reset to 0.
- Undefined: single register stage, 1-cycle lag.

Decomposition:
- Package bridge_pkg holds:
  - state enum {IDLE, ACCESS, RESP}
  - ERR_RDATA=32'hFFFF_FFFF
  - default BASE_ADDR/STRIDE/SPAN constants
  - counter width function clog2(TIMEOUT+1)
- One sub-module, bridge_addr_decode (combinational, parameters N_DEV/BASE_ADDR/STRIDE/SPAN): pr_addr → one-hot hit vector plus any_hit.

Test Plan:
- Write 0xDEADBEEF to 0x7f14, be=4'hF; slot 1 acks on its first strobe cycle → dev_we=4'b0010 for 1 cycle, dev_addr=0x7f14>>2, pr_ready at cycle 2, pr_err=0.
- Read 0x7f00; slot 0 delays ack 3 cycles and returns 0x12345678 → dev_re=4'b0001 held 4 cycles, pr_rd=0x12345678 with pr_ready at cycle 5.
- Read 0x7f0C (gap between SPAN and STRIDE) → no strobe, pr_ready at cycle 1, pr_err=1, pr_rd=0xFFFFFFFF.
- Read slot 2 with ack never asserted, TIMEOUT=15 → strobe held 15 cycles, then pr_ready, pr_err=1, pr_rd=0xFFFFFFFF; slot 3 ack pulsed meanwhile is ignored.
- pr_we=pr_re=1 at 0x7f30 → write strobe only. Also: assert reset_n=0 mid-ACCESS → dev_re drops same cycle; state IDLE after release; no pr_ready.
- dev_irq=4'b1000 pulse → irq_out[3] rises 1 cycle later (2 cycles with BRIDGE_IRQ_SYNC_EN).
